// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed multi-digit 7-segment display driver. A packed BCD word is
// scanned one digit per slot onto a shared segment bus with one-hot digit
// enables. Each slot opens with a one-cycle blanking gap so the segment pattern
// of the previous digit never ghosts onto the next one. A full frame is
// rendered from a snapshot of the inputs taken at the start of the frame.
//
// Optional feature macro: SEG7_HEX_EN
//   defined   -> codes 10..15 render as hex letters A b C d E F
//   undefined -> codes 10..15 render blank
//
// Parameters
//   DIGITS       number of scanned digits (1..8)
//   PRESCALE     clock cycles per digit slot (>= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   value        packed nibbles, nibble k = value[4k+3:4k], digit 0 lowest
//   dp_mask      bit k lights the decimal point of digit k
//   en           1 = display on, 0 = segments off and no digit selected
//   inv          0 = common-anode (segment on = 0), 1 = active-high segments
//   blank_lz     1 = suppress leading zeros
//   seg          registered segment bus {p,g,f,e,d,c,b,a}
//   dig_sel      registered one-hot digit enable, active-high
//   frame_start  registered one-cycle pulse at the start of each frame
// ----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  en,
    input  logic                  inv,
    input  logic                  blank_lz,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_start
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [KW-1:0] KMAX = KW'(DIGITS - 1);

    // Active-high gfedcba glyph for one nibble.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] g;
        unique case (nib)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1101111;
`ifdef SEG7_HEX_EN
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;
            4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;
            4'hF: g = 7'b1110001;
`else
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: g = 7'b0000000;
`endif
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Slot / digit counters
    // ------------------------------------------------------------------
    logic [PW-1:0] p_q, p_d;
    logic [KW-1:0] k_q, k_d;
    logic          p_wrap;
    logic          slot_gap;    // first cycle of a slot
    logic          frame_edge;  // first cycle of a frame

    always_comb begin
        p_wrap     = (p_q == PMAX);
        p_d        = p_wrap ? '0 : p_q + 1'b1;
        k_d        = k_q;
        if (p_wrap) begin
            k_d = (k_q == KMAX) ? '0 : k_q + 1'b1;
        end
        slot_gap   = (p_q == '0);
        frame_edge = slot_gap && (k_q == '0);
    end

    // ------------------------------------------------------------------
    // Frame snapshot
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] snap_value_q;
    logic [DIGITS-1:0]   snap_dp_q;
    logic                snap_blz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_value_q <= '0;
            snap_dp_q    <= '0;
            snap_blz_q   <= 1'b0;
        end else if (frame_edge) begin
            snap_value_q <= value;
            snap_dp_q    <= dp_mask;
            snap_blz_q   <= blank_lz;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero detection: zero_from[i] = nibbles i..DIGITS-1 all zero.
    // ------------------------------------------------------------------
    logic [DIGITS:0]   zero_from;
    logic [DIGITS-1:0] lz_blank;

    always_comb begin
        zero_from         = '0;
        zero_from[DIGITS] = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (snap_value_q[4*i +: 4] == 4'h0);
        end
        lz_blank = '0;
        // Digit 0 always shows, even for an all-zero value.
        for (int i = 1; i < int'(DIGITS); i++) begin
            lz_blank[i] = snap_blz_q && zero_from[i];
        end
    end

    // ------------------------------------------------------------------
    // Current-digit selection and pattern build
    // ------------------------------------------------------------------
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic [DIGITS-1:0] cur_onehot;

    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (k_q == KW'(i)) begin
                cur_nib       = snap_value_q[4*i +: 4];
                cur_dp        = snap_dp_q[i];
                cur_blank     = lz_blank[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    logic [7:0]        seg_on;   // active-high {p,g,f,e,d,c,b,a}
    logic [7:0]        seg_off;
    logic [7:0]        seg_d;
    logic [DIGITS-1:0] dig_sel_d;
    logic              lit;

    always_comb begin
        seg_on    = {cur_dp, cur_blank ? 7'b0000000 : decode(cur_nib)};
        seg_off   = inv ? 8'h00 : 8'hFF;
        // en and inv act live; only the digit content comes from the snapshot.
        lit       = en && !slot_gap;
        seg_d     = seg_off;
        dig_sel_d = '0;
        if (lit) begin
            seg_d     = inv ? seg_on : ~seg_on;
            dig_sel_d = cur_onehot;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic [7:0]        seg_q;
    logic [DIGITS-1:0] dig_sel_q;
    logic              frame_start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q           <= '0;
            k_q           <= '0;
            seg_q         <= 8'hFF;
            dig_sel_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            p_q           <= p_d;
            k_q           <= k_d;
            seg_q         <= seg_d;
            dig_sel_q     <= dig_sel_d;
            frame_start_q <= frame_edge;
        end
    end

    assign seg         = seg_q;
    assign dig_sel     = dig_sel_q;
    assign frame_start = frame_start_q;

endmodule
